multdiv_iter: RTL



---
 rtl/multdiv_iter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per clock,
// signed/unsigned operands, double-width product, exception flag and abort-on-restart.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // The most negative value maps to the unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH-1:0] m;
    if (sgn && v[WIDTH-1]) begin
      m = ~v + ONE;
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               b_neg_q, b_neg_d;
  logic               sgn_q, sgn_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               exc_q, exc_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;

  logic               start_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_sub_s;
  logic               div_ge_s;
  logic               a_neg_s;
  logic               q_neg_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  assign start_s     = ctrl_MULT | ctrl_DIV;
  assign mul_sum_s   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, ma_q};
  assign div_shift_s = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_sub_s   = div_shift_s - {1'b0, mb_q};
  assign div_ge_s    = (div_shift_s >= {1'b0, mb_q});
  assign a_neg_s     = sgn_q & a_q[WIDTH-1];
  assign q_neg_s     = a_neg_s ^ b_neg_q;
  assign prod_s      = q_neg_s ? (~p_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_q;
  assign quo_s       = q_neg_s ? (~p_q[WIDTH-1:0] + ONE) : p_q[WIDTH-1:0];
  assign rem_s       = a_neg_s ? (~p_q[2*WIDTH-1:WIDTH] + ONE) : p_q[2*WIDTH-1:WIDTH];

  // Next-state, iteration datapath and result capture; a start always wins over the current op.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    a_d      = a_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    b_neg_d  = b_neg_q;
    sgn_d    = sgn_q;
    div_d    = div_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    exc_d    = exc_q;
    if (start_s) begin
      a_d     = data_operandA;
      ma_d    = magnitude(data_operandA, ctrl_SIGNED);
      mb_d    = magnitude(data_operandB, ctrl_SIGNED);
      b_neg_d = ctrl_SIGNED & data_operandB[WIDTH-1];
      sgn_d   = ctrl_SIGNED;
      div_d   = ~ctrl_MULT;
      cnt_d   = {CNT_W{1'b0}};
      if (ctrl_MULT) begin
        state_d = S_MUL;
        p_d     = {ZERO, magnitude(data_operandB, ctrl_SIGNED)};
      end else begin
        state_d = S_DIV;
        p_d     = {ZERO, magnitude(data_operandA, ctrl_SIGNED)};
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_MUL: begin
          if (p_q[0]) begin
            p_d = {mul_sum_s, p_q[WIDTH-1:1]};
          end else begin
            p_d = {1'b0, p_q[2*WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end else begin
            state_d = S_MUL;
          end
        end
        S_DIV: begin
          if (div_ge_s) begin
            p_d = {div_sub_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
          end else begin
            p_d = {div_shift_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DIV;
          end
        end
        S_FIX: begin
          state_d = S_DONE;
          if (!div_q) begin
            res_d    = prod_s[WIDTH-1:0];
            res_hi_d = prod_s[2*WIDTH-1:WIDTH];
            if (sgn_q) begin
              exc_d = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
            end else begin
              exc_d = (p_q[2*WIDTH-1:WIDTH] != ZERO);
            end
          end else if (mb_q == ZERO) begin
            exc_d    = 1'b1;
            res_d    = ZERO;
            res_hi_d = a_q;
          end else if (sgn_q && (a_q == MIN_VAL) && b_neg_q && (mb_q == ONE)) begin
            exc_d    = 1'b1;
            res_d    = MIN_VAL;
            res_hi_d = ZERO;
          end else begin
            exc_d    = 1'b0;
            res_d    = quo_s;
            res_hi_d = rem_s;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    rdy_d  = (state_d == S_DONE);
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      p_q      <= {(2*WIDTH){1'b0}};
      a_q      <= ZERO;
      ma_q     <= ZERO;
      mb_q     <= ZERO;
      b_neg_q  <= 1'b0;
      sgn_q    <= 1'b0;
      div_q    <= 1'b0;
      res_q    <= ZERO;
      res_hi_q <= ZERO;
      exc_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      a_q      <= a_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      b_neg_q  <= b_neg_d;
      sgn_q    <= sgn_d;
      div_q    <= div_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      exc_q    <= exc_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_result_hi = res_hi_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
